// File: rtl/beta_pkg.sv
// Shared types and constants for the beta pipeline stage buffers.
package beta_pkg;

  typedef enum logic [1:0] {
    PB_EMPTY = 2'd0,
    PB_HALF  = 2'd1,
    PB_FULL  = 2'd2
  } pipe_buf_state_t;

  localparam logic [31:0] BETA_NOP = 32'h00000013;

  // Entry count held in each buffer state; the unused encoding counts as empty.
  function automatic logic [1:0] pb_occupancy(input pipe_buf_state_t st);
    logic [1:0] occ;
    case (st)
      PB_EMPTY: occ = 2'd0;
      PB_HALF:  occ = 2'd1;
      PB_FULL:  occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/beta_pipe_slot.sv
// Load-enabled {pc, data} register; resets to a NOP at PC 0.
module beta_pipe_slot
  import beta_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 i_load,
  input  logic [AddrWidth-1:0] i_pc,
  input  logic [DataWidth-1:0] i_data,
  output logic [AddrWidth-1:0] o_pc,
  output logic [DataWidth-1:0] o_data
);

  logic [AddrWidth-1:0] r_pc;
  logic [DataWidth-1:0] r_data;

  // Slot storage: captured only when loaded.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_pc   <= {AddrWidth{1'b0}};
      r_data <= DataWidth'(BETA_NOP);
    end else if (i_load) begin
      r_pc   <= i_pc;
      r_data <= i_data;
    end else begin
      r_pc   <= r_pc;
      r_data <= r_data;
    end
  end

  assign o_pc   = r_pc;
  assign o_data = r_data;

endmodule

// File: rtl/beta_pipe_stage_buffer.sv
// Two-entry elastic pipe register (head + skid) obeying pipeline stall/flush.
module beta_pipe_stage_buffer
  import beta_pkg::*;
#(
  parameter int DataWidth     = 32,
  parameter int AddrWidth     = 32,
  parameter int FlushCntWidth = 8
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     up_valid_i,
  input  logic [AddrWidth-1:0]     up_pc_i,
  input  logic [DataWidth-1:0]     up_data_i,
  output logic                     up_ready_o,
  output logic                     dn_valid_o,
  output logic [AddrWidth-1:0]     dn_pc_o,
  output logic [DataWidth-1:0]     dn_data_o,
  input  logic                     dn_ready_i,
  input  logic                     pip_stall_i,
  input  logic                     pip_flush_i,
  output logic                     pip_busy_o,
  output logic [1:0]               pip_occupancy_o,
  output logic [FlushCntWidth-1:0] pip_flush_cnt_o
);

  pipe_buf_state_t          r_state;
  pipe_buf_state_t          w_state_nxt;
  logic [FlushCntWidth-1:0] r_flush_cnt;
  logic [FlushCntWidth:0]   w_flush_sum;
  logic [1:0]               w_occ;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_head_load;
  logic                     w_skid_load;
  logic                     w_head_from_skid;
  logic [AddrWidth-1:0]     w_skid_pc;
  logic [DataWidth-1:0]     w_skid_data;
  logic [AddrWidth-1:0]     w_head_pc_in;
  logic [DataWidth-1:0]     w_head_data_in;

  // Ready depends only on state and control inputs, never on dn_ready_i.
  assign up_ready_o = ((r_state == PB_EMPTY) || (r_state == PB_HALF)) & ~pip_stall_i & ~pip_flush_i;
  assign dn_valid_o = (r_state == PB_HALF) || (r_state == PB_FULL);
  assign pip_busy_o = (r_state == PB_FULL);
  assign w_occ      = pb_occupancy(r_state);
  assign pip_occupancy_o = w_occ;
  assign pip_flush_cnt_o = r_flush_cnt;

  assign w_push = up_valid_i & up_ready_o;
  assign w_pop  = dn_valid_o & dn_ready_i & ~pip_stall_i & ~pip_flush_i;

  assign w_head_pc_in   = w_head_from_skid ? w_skid_pc   : up_pc_i;
  assign w_head_data_in = w_head_from_skid ? w_skid_data : up_data_i;

  assign w_flush_sum = {1'b0, r_flush_cnt} + (FlushCntWidth + 1)'(w_occ);

  // Next-state and slot load decode; flush overrides everything.
  always_comb begin
    w_state_nxt      = r_state;
    w_head_load      = 1'b0;
    w_skid_load      = 1'b0;
    w_head_from_skid = 1'b0;
    case (r_state)
      PB_EMPTY: begin
        if (w_push) begin
          w_head_load = 1'b1;
          w_state_nxt = PB_HALF;
        end else begin
          w_state_nxt = PB_EMPTY;
        end
      end
      PB_HALF: begin
        if (w_push && w_pop) begin
          w_head_load = 1'b1;
          w_state_nxt = PB_HALF;
        end else if (w_push) begin
          w_skid_load = 1'b1;
          w_state_nxt = PB_FULL;
        end else if (w_pop) begin
          w_state_nxt = PB_EMPTY;
        end else begin
          w_state_nxt = PB_HALF;
        end
      end
      PB_FULL: begin
        if (w_pop) begin
          w_head_load      = 1'b1;
          w_head_from_skid = 1'b1;
          w_state_nxt      = PB_HALF;
        end else begin
          w_state_nxt = PB_FULL;
        end
      end
      default: begin
        w_state_nxt = PB_EMPTY;
      end
    endcase
    if (pip_flush_i) begin
      w_state_nxt = PB_EMPTY;
      w_head_load = 1'b0;
      w_skid_load = 1'b0;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  // Buffer state register.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state <= PB_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Saturating count of entries discarded by flushes.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_flush_cnt <= {FlushCntWidth{1'b0}};
    end else if (pip_flush_i) begin
      r_flush_cnt <= w_flush_sum[FlushCntWidth] ? {FlushCntWidth{1'b1}} : w_flush_sum[FlushCntWidth-1:0];
    end else begin
      r_flush_cnt <= r_flush_cnt;
    end
  end

  beta_pipe_slot #(.DataWidth(DataWidth), .AddrWidth(AddrWidth)) u_head (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .i_load (w_head_load),
    .i_pc   (w_head_pc_in),
    .i_data (w_head_data_in),
    .o_pc   (dn_pc_o),
    .o_data (dn_data_o)
  );

  beta_pipe_slot #(.DataWidth(DataWidth), .AddrWidth(AddrWidth)) u_skid (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .i_load (w_skid_load),
    .i_pc   (up_pc_i),
    .i_data (up_data_i),
    .o_pc   (w_skid_pc),
    .o_data (w_skid_data)
  );

endmodule

// File: tb/tb_beta_pipe_stage_buffer.sv
// Scoreboard bench for beta_pipe_stage_buffer: entries queued on push, compared on pop.
module tb_beta_pipe_stage_buffer;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  logic        clk;
  logic        rstn;
  logic        up_valid;
  logic [31:0] up_pc;
  logic [31:0] up_data;
  logic        up_ready;
  logic        dn_valid;
  logic [31:0] dn_pc;
  logic [31:0] dn_data;
  logic        dn_ready;
  logic        stall;
  logic        flush;
  logic        busy;
  logic [1:0]  occ;
  logic [7:0]  fcnt;

  ent_t q[$];
  int   fcnt_model;
  int   errors;
  int   checks;

  beta_pipe_stage_buffer #(.DataWidth(32), .AddrWidth(32), .FlushCntWidth(8)) dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .up_valid_i      (up_valid),
    .up_pc_i         (up_pc),
    .up_data_i       (up_data),
    .up_ready_o      (up_ready),
    .dn_valid_o      (dn_valid),
    .dn_pc_o         (dn_pc),
    .dn_data_o       (dn_data),
    .dn_ready_i      (dn_ready),
    .pip_stall_i     (stall),
    .pip_flush_i     (flush),
    .pip_busy_o      (busy),
    .pip_occupancy_o (occ),
    .pip_flush_cnt_o (fcnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock: check ready, compare popped head, then advance the model.
  task automatic step();
    logic exp_ready;
    logic do_push;
    logic do_pop;
    ent_t e;
    #1;
    exp_ready = (q.size() < 2) && !stall && !flush;
    checks++;
    if (up_ready !== exp_ready) begin
      errors++;
      $display("FAIL up_ready: got %b expected %b at %0t", up_ready, exp_ready, $time);
    end
    do_push = rstn && up_valid && exp_ready;
    do_pop  = rstn && (q.size() > 0) && dn_ready && !stall && !flush;
    if (do_pop) begin
      e = q[0];
      checks++;
      if (dn_valid !== 1'b1 || dn_pc !== e.pc || dn_data !== e.data) begin
        errors++;
        $display("FAIL pop: got v=%b pc=%h data=%h expected pc=%h data=%h", dn_valid, dn_pc, dn_data, e.pc, e.data);
      end
    end
    @(posedge clk);
    if (!rstn) begin
      q.delete();
      fcnt_model = 0;
    end else if (flush) begin
      fcnt_model = fcnt_model + q.size();
      if (fcnt_model > 255) fcnt_model = 255;
      q.delete();
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{pc: up_pc, data: up_data});
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    up_valid = 1'b0;
    dn_ready = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic fill_two(input logic [31:0] pc0);
    dn_ready = 1'b0;
    up_valid = 1'b1;
    up_pc = pc0;         up_data = pc0 ^ 32'hA5A5_0000; step();
    up_pc = pc0 + 32'd4; up_data = pc0 ^ 32'h5A5A_0000; step();
    up_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    up_pc = 32'd0;
    up_data = 32'd0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (dn_valid !== 1'b0 || dn_pc !== 32'd0 || dn_data !== 32'h0000_0013) begin
      errors++;
      $display("FAIL reset_dn: got v=%b pc=%h data=%h expected 0/0/00000013", dn_valid, dn_pc, dn_data);
    end
    checks++;
    if (fcnt !== 8'd0 || occ !== 2'd0 || busy !== 1'b0 || up_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctl: got fcnt=%0d occ=%0d busy=%b rdy=%b expected 0/0/0/1", fcnt, occ, busy, up_ready);
    end
    rstn = 1'b1;
    q.delete();
    fcnt_model = 0;
  endtask

  task automatic test_stream();
    dn_ready = 1'b1;
    up_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      up_pc   = 32'h100 + 32'(4 * i);
      up_data = 32'hA + 32'(i);
      step();
      checks++;
      if (occ !== 2'd1 || dn_valid !== 1'b1 || dn_pc !== up_pc) begin
        errors++;
        $display("FAIL stream: got occ=%0d v=%b pc=%h expected 1/1/%h", occ, dn_valid, dn_pc, up_pc);
      end
    end
    up_valid = 1'b0;
    step();
    checks++;
    if (occ !== 2'd0 || dn_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain: got occ=%0d v=%b expected 0/0", occ, dn_valid);
    end
  endtask

  task automatic test_full();
    fill_two(32'h200);
    checks++;
    if (occ !== 2'd2 || busy !== 1'b1 || up_ready !== 1'b0 || dn_pc !== 32'h200) begin
      errors++;
      $display("FAIL full: got occ=%0d busy=%b rdy=%b pc=%h expected 2/1/0/200", occ, busy, up_ready, dn_pc);
    end
    dn_ready = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || occ !== 2'd1 || dn_pc !== 32'h204) begin
      errors++;
      $display("FAIL full_pop1: got busy=%b occ=%0d pc=%h expected 0/1/204", busy, occ, dn_pc);
    end
    step();
    checks++;
    if (occ !== 2'd0) begin
      errors++;
      $display("FAIL full_pop2: got occ=%0d expected 0", occ);
    end
  endtask

  task automatic test_stall();
    fill_two(32'h300);
    dn_ready = 1'b1;
    stall = 1'b1;
    up_valid = 1'b1;
    up_pc = 32'h3FC;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dn_pc !== 32'h300 || occ !== 2'd2) begin
        errors++;
        $display("FAIL stall: got pc=%h occ=%0d expected 300/2", dn_pc, occ);
      end
    end
    stall = 1'b0;
    up_valid = 1'b0;
    step();
    step();
    checks++;
    if (occ !== 2'd0 || dn_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain: got occ=%0d v=%b expected 0/0", occ, dn_valid);
    end
  endtask

  task automatic test_flush();
    fill_two(32'h400);
    flush = 1'b1;
    stall = 1'b1;
    up_valid = 1'b1;
    up_pc = 32'h4F0;
    step();
    idle_inputs();
    checks++;
    if (dn_valid !== 1'b0 || occ !== 2'd0 || fcnt !== 8'(fcnt_model) || fcnt !== 8'd2) begin
      errors++;
      $display("FAIL flush: got v=%b occ=%0d fcnt=%0d expected 0/0/2", dn_valid, occ, fcnt);
    end
    dn_ready = 1'b1;
    step();
    step();
    checks++;
    if (dn_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop: got v=%b expected 0", dn_valid);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 130; i++) begin
      fill_two(32'h1000 + 32'(16 * i));
      flush = 1'b1;
      step();
      flush = 1'b0;
    end
    checks++;
    if (fcnt !== 8'(fcnt_model) || fcnt !== 8'd255) begin
      errors++;
      $display("FAIL saturate: got fcnt=%0d expected 255", fcnt);
    end
    fill_two(32'h2000);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (fcnt !== 8'd255) begin
      errors++;
      $display("FAIL saturate_hold: got fcnt=%0d expected 255", fcnt);
    end
  endtask

  task automatic test_reset_full();
    fill_two(32'h500);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    checks++;
    if (dn_valid !== 1'b0 || dn_data !== 32'h0000_0013 || fcnt !== 8'd0 || up_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_full: got v=%b data=%h fcnt=%0d rdy=%b expected 0/00000013/0/1", dn_valid, dn_data, fcnt, up_ready);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      up_valid = 1'($urandom_range(0, 1));
      dn_ready = 1'($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 7) == 0);
      flush    = ($urandom_range(0, 19) == 0);
      up_pc    = $urandom;
      up_data  = $urandom;
      step();
    end
    idle_inputs();
    dn_ready = 1'b1;
    for (int i = 0; i < 8 && q.size() > 0; i++) step();
    checks++;
    if (q.size() != 0 || occ !== 2'd0) begin
      errors++;
      $display("FAIL b2b_drain: got occ=%0d model=%0d expected 0", occ, q.size());
    end
    checks++;
    if (fcnt !== 8'(fcnt_model)) begin
      errors++;
      $display("FAIL b2b_fcnt: got %0d expected %0d", fcnt, fcnt_model);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    fcnt_model = 0;
    test_reset();
    test_stream();
    test_full();
    test_stall();
    test_flush();
    test_back_to_back();
    test_saturate();
    test_reset_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/beta_pipe_stage_buffer.md
Name: beta_pipe_stage_buffer

Overview:
- Two-entry elastic pipeline register placed between two stages (IF->DEC or DEC->EXE); one instance per pipe.
- Receiving end of the pipeline control unit's stall/flush outputs: obeys pip_stall_i/pip_flush_i and returns a busy indication to the control unit.
- Carries PC plus instruction/payload word downstream over a valid/ready handshake.
- Decouples producer and consumer at full throughput, with no combinational path from dn_ready_i to up_ready_o.

Parameters:
- DataWidth, 32, width of the instruction/payload word.
- AddrWidth, 32, width of the PC tag.
- FlushCntWidth, 8, width of the saturating flushed-entry counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  reset, synchronous, active-low.
- up_valid_i  in  1  producer stage offers an entry.
- up_pc_i  in  AddrWidth  PC of the offered entry.
- up_data_i  in  DataWidth  payload of the offered entry.
- up_ready_o  out  1  buffer accepts this cycle.
- dn_valid_o  out  1  head entry valid.
- dn_pc_o  out  AddrWidth  head PC.
- dn_data_o  out  DataWidth  head payload.
- dn_ready_i  in  1  consumer stage takes the head.
- pip_stall_i  in  1  stall from pipeline control unit.
- pip_flush_i  in  1  flush from pipeline control unit.
- pip_busy_o  out  1  buffer full (to control unit busy input).
- pip_occupancy_o  out  2  entry count, 0..2.
- pip_flush_cnt_o  out  FlushCntWidth  total entries discarded by flushes, saturating.

Behaviour:
- Storage: head slot (drives dn_*) and skid slot.
- States: EMPTY (0 entries), HALF (head only), FULL (head and skid).
- Definitions:
  - push = up_valid_i & up_ready_o.
  - pop = dn_valid_o & dn_ready_i & ~pip_stall_i & ~pip_flush_i.
  - up_ready_o = (state != FULL) & ~pip_stall_i & ~pip_flush_i. Combinational only from state and the stall/flush inputs.
  - dn_valid_o = (state != EMPTY). It is not masked by stall; the consumer must honour pip_stall_i.
  - pip_busy_o = (state == FULL).
  - pip_occupancy_o = 0, 1 or 2 according to state.
- Transitions, evaluated at the rising edge:
  - EMPTY, push: head <= up, go to HALF.
  - HALF, push & pop: head <= up, stay in HALF (1 entry per cycle sustained).
  - HALF, push only: skid <= up, go to FULL.
  - HALF, pop only: go to EMPTY.
  - FULL, pop: head <= skid, go to HALF. Push is impossible in FULL.
  - Otherwise hold. Slot registers are written only on the loads listed above.
- Latency: an entry pushed in cycle N appears on dn_* in cycle N+1 when it lands in the head slot.
- Ordering: strict FIFO; the skid entry always follows the head entry.
- Stall: state and slots are frozen; no push, no pop; dn_* held stable.
- Flush:
  - Next state is EMPTY regardless of valid/ready/stall; flush has priority over stall.
  - Any entry offered in the same cycle is dropped.
  - pip_flush_cnt_o <= min(pip_flush_cnt_o + occupancy, 2^FlushCntWidth - 1).
  - Slot contents need not be cleared.
- Reset (rstn_i low at the edge):
  - State goes to EMPTY; dn_valid_o=0; dn_pc_o=0; dn_data_o=BETA_NOP (32'h00000013, zero-extended or truncated to DataWidth); pip_flush_cnt_o=0.
  - Reset mid-operation discards contents and does not increment pip_flush_cnt_o.
- Width rules:
  - Counter addition is done at FlushCntWidth+1 bits, then saturated.
  - Occupancy is a 2-bit unsigned value.
- Illegal state encoding (3) recovers to EMPTY on the next edge.

Decomposition:
- beta_pkg gains:
  - typedef enum logic[1:0] pipe_buf_state_t {PB_EMPTY, PB_HALF, PB_FULL}.
  - Constant BETA_NOP = 32'h00000013.
- One sub-module is natural: beta_pipe_slot, a load-enabled {pc,data} register with reset value {0, BETA_NOP}, instantiated twice (head, skid).
- The FSM and flush counter stay in the top module.

Test Plan:
- Reset, then up_valid_i=1 with pc=0x100, data=0xA, dn_ready_i=1 held → dn_valid_o=1 and dn_pc_o=0x100 one cycle later; streaming pcs 0x100,0x104,0x108 emerge back-to-back; occupancy stays 1.
- dn_ready_i=0, push 0x200 then 0x204 → occupancy=2, pip_busy_o=1, up_ready_o=0. Raise dn_ready_i → 0x200 then 0x204 delivered in order, busy drops after the first pop.
- FULL state, pip_stall_i=1 for 3 cycles with dn_ready_i=1 → no pop, dn_pc_o constant, up_ready_o=0. Release stall → normal drain.
- FULL, pip_flush_i=1 together with up_valid_i=1 and pip_stall_i=1 → next cycle EMPTY, dn_valid_o=0, pip_flush_cnt_o=2, offered entry absent afterwards.
- 130 flushes taken while FULL (FlushCntWidth=8) → pip_flush_cnt_o saturates at 255 and holds.
- rstn_i=0 asserted while FULL → next cycle dn_valid_o=0, dn_data_o=0x00000013, pip_flush_cnt_o=0, up_ready_o=1.
